// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-facing signal bundle of the branch predictor.
// The slave side is the predictor; the master side is the surrounding pipeline.
interface branch_predict_unit_if #(
   parameter int unsigned ADDR_W = 64
);
   logic              FetchValid;
   logic [ADDR_W-1:0] FetchPC;
   logic              PredValid;
   logic              PredTaken;
   logic              ExValid;
   logic [ADDR_W-1:0] ExPC;
   logic              ExTaken;
   logic              ExPredicted;
   logic [ADDR_W-1:0] ExTarget;
   logic              Flush;
   logic [ADDR_W-1:0] RedirectPC;
   logic [31:0]       MispredictCount;

   modport master (
      output FetchValid, FetchPC, ExValid, ExPC, ExTaken, ExPredicted, ExTarget,
      input  PredValid, PredTaken, Flush, RedirectPC, MispredictCount
   );

   modport slave (
      input  FetchValid, FetchPC, ExValid, ExPC, ExTaken, ExPredicted, ExTarget,
      output PredValid, PredTaken, Flush, RedirectPC, MispredictCount
   );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped 2-bit saturating-counter branch predictor with one-cycle
// prediction latency and a single-cycle flush/redirect on misprediction.
module branch_predict_unit #(
   parameter int unsigned ENTRIES    = 16,
   parameter int unsigned INDEX_BITS = 4,
   parameter int unsigned ADDR_W     = 64
) (
   input logic                  clk,
   input logic                  reset_n,
   branch_predict_unit_if.slave bus
);
   localparam int unsigned CNT_W = 32;
   localparam int unsigned CTR_W = 2;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_FLUSH  = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [CTR_W-1:0]        table_q [ENTRIES];

   logic                    pred_valid_q, pred_valid_d;
   logic                    pred_taken_q, pred_taken_d;
   logic                    flush_q, flush_d;
   logic [ADDR_W-1:0]       redirect_q, redirect_d;
   logic [CNT_W-1:0]        count_q, count_d;

   logic [INDEX_BITS-1:0]   fetch_idx_c;
   logic [INDEX_BITS-1:0]   ex_idx_c;
   logic [CTR_W-1:0]        ex_ctr_c;
   logic [CTR_W-1:0]        ctr_next_c;
   logic                    accept_c;
   logic                    mispredict_c;

   assign fetch_idx_c = bus.FetchPC[INDEX_BITS+1:2];
   assign ex_idx_c    = bus.ExPC[INDEX_BITS+1:2];

   // Only the index field of the fetch address matters to the table.
   logic unused_fetch_pc_bits;
   assign unused_fetch_pc_bits = ^{bus.FetchPC[ADDR_W-1:INDEX_BITS+2], bus.FetchPC[1:0]};

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      pred_valid_d = 1'b0;
      pred_taken_d = 1'b0;
      flush_d      = 1'b0;
      redirect_d   = redirect_q;
      count_d      = count_q;
      ex_ctr_c     = table_q[ex_idx_c];
      ctr_next_c   = ex_ctr_c;
      accept_c     = 1'b0;
      mispredict_c = 1'b0;

      if (bus.ExTaken) begin
         if (ex_ctr_c != 2'b11) ctr_next_c = ex_ctr_c + CTR_W'(1);
      end else begin
         if (ex_ctr_c != 2'b00) ctr_next_c = ex_ctr_c - CTR_W'(1);
      end

      case (state_q)
         ST_NORMAL: begin
            accept_c     = bus.ExValid;
            mispredict_c = accept_c && (bus.ExTaken != bus.ExPredicted);
            if (mispredict_c) begin
               state_d    = ST_FLUSH;
               flush_d    = 1'b1;
               redirect_d = bus.ExTaken ? bus.ExTarget : bus.ExPC + ADDR_W'(4);
               if (count_q != '1) count_d = count_q + CNT_W'(1);
            end
         end
         ST_FLUSH: begin
            state_d = ST_NORMAL;
         end
         default: begin
            state_d = ST_NORMAL;
         end
      endcase

      // Fetches during a flush or alongside a detected mispredict are wrong-path.
      pred_valid_d = bus.FetchValid && (state_q == ST_NORMAL) && !mispredict_c;
      pred_taken_d = table_q[fetch_idx_c][1];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_NORMAL;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         flush_q      <= 1'b0;
         redirect_q   <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         flush_q      <= flush_d;
         redirect_q   <= redirect_d;
         count_q      <= count_d;
      end
   end

   // Counter table; the fetch read above sees the pre-update value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
      end else if (accept_c) begin
         table_q[ex_idx_c] <= ctr_next_c;
      end
   end

   assign bus.PredValid       = pred_valid_q;
   assign bus.PredTaken       = pred_taken_q;
   assign bus.Flush           = flush_q;
   assign bus.RedirectPC      = redirect_q;
   assign bus.MispredictCount = count_q;

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Consumer side of the execute-stage branch decision. It holds a direct-mapped table of 2-bit saturating counters and gives fetch a taken/not-taken prediction one cycle after each fetch request. When execute reports a resolved branch (the taken/not-taken `sel` result plus the prediction that travelled with it), the block updates the table. On a mismatch it issues a one-cycle pipeline flush and a redirect PC. It sits between the fetch stage and the execute-stage branch comparator.

## Interface
- `ENTRIES`, 16: number of counters; power of two, at least 2.
- `INDEX_BITS`, 4: log2(`ENTRIES`).
- `ADDR_W`, 64: PC width.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `FetchValid`  in  1  a fetch PC is presented this cycle.
- `FetchPC`  in  ADDR_W  fetch address; index = `FetchPC[INDEX_BITS+1:2]`.
- `PredValid`  out  1  `PredTaken` is valid this cycle.
- `PredTaken`  out  1  predicted direction for the previous cycle's fetch.
- `ExValid`  in  1  a branch resolved in execute this cycle.
- `ExPC`  in  ADDR_W  PC of the resolved branch; indexed the same way as `FetchPC`.
- `ExTaken`  in  1  actual direction (branch comparator `sel`).
- `ExPredicted`  in  1  prediction carried with that branch.
- `ExTarget`  in  ADDR_W  branch target address.
- `Flush`  out  1  squash younger instructions; pulses one cycle.
- `RedirectPC`  out  ADDR_W  correct next PC; valid while `Flush`=1.
- `MispredictCount`  out  32  saturating count of mispredictions.

## Operation
- **Table:** `ENTRIES` counters of 2 bits each. Encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken. Prediction is bit [1] of the indexed counter.
- **Update condition:** an update is accepted when `ExValid`=1 and the state is NORMAL.
  - `ExTaken`=1: counter increments, saturating at 11.
  - `ExTaken`=0: counter decrements, saturating at 00.
- **Misprediction:** an accepted update with `ExTaken`≠`ExPredicted`.
  - `RedirectPC` = `ExTarget` if `ExTaken`=1, else `ExPC`+4 (modulo 2^ADDR_W).
  - `MispredictCount` increments, holding at 0xFFFFFFFF once reached.
- **State machine:**
  - NORMAL → FLUSH on a misprediction. `Flush`=1 during the FLUSH cycle.
  - FLUSH → NORMAL unconditionally after one cycle.
  - In FLUSH, `ExValid` is ignored: no table update, no counting, no new flush. That branch is on the wrong path.
- **Prediction:** `PredValid` is registered from `FetchValid`. It is forced to 0 if the state is FLUSH or a misprediction is detected in the same cycle; the fetch is then wrong-path.
- **Same-index read and update:** fetch and update hitting the same index in one cycle read the pre-update counter value.
- **Reset** (`reset_n`=0 at an edge):
  - All counters → 01.
  - State → NORMAL.
  - `PredValid`, `PredTaken`, `Flush` → 0.
  - `RedirectPC` → 0; `MispredictCount` → 0.
  - Reset overrides a pending or active flush.

## Timing
- **Prediction latency:** 1 cycle. A fetch in cycle t gives `PredValid`/`PredTaken` in cycle t+1, computed from the table contents during cycle t.
- **Update latency:** an update in cycle t is written at the end of cycle t. It is visible to a fetch in cycle t+1 and to `PredTaken` in t+2.
- **Flush latency:** a misprediction in cycle t gives `Flush`=1 and a valid `RedirectPC` in cycle t+1 only. `Flush`=0 in t+2.
  - `RedirectPC` holds its last value when `Flush`=0.
- **Back-to-back mispredictions:** cannot produce consecutive flush pulses. A misprediction presented during FLUSH is dropped; the minimum `Flush` spacing is 2 cycles.
- **Registered outputs:** all outputs come from registers; there is no combinational input-to-output path.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles, release, fetch PC 0x100 → `PredValid`=1, `PredTaken`=0 next cycle, `Flush`=0, `MispredictCount`=0.
- **Training:**
  - Resolve PC 0x100 taken with `ExPredicted`=0 → `Flush`=1 for one cycle, `RedirectPC`=`ExTarget`=0x200, count=1.
  - Resolve the same PC taken again with `ExPredicted`=1 → no flush.
  - Fetch 0x100 → `PredTaken`=1.
- **Not-taken mispredict:** resolve PC 0x40 not-taken with `ExPredicted`=1 → `RedirectPC`=0x44, `Flush` pulses one cycle.
- **Saturation:**
  - 5 taken updates to one index → counter 11.
  - One not-taken update → still predicts taken.
  - A second not-taken update → predicts not-taken.
- **Flush-cycle drop:** mispredicts in cycles t and t+1 → single `Flush` at t+1, count=1, no table change from the t+1 update; a `FetchValid` in cycle t gives `PredValid`=0.
- **Same-index ordering and aliasing, then mid-flush reset:**
  - Fetch 0x100 and update 0x140 (same index with `ENTRIES`=16) in the same cycle → prediction shows the old value.
  - Then assert reset during `Flush` → `Flush`=0 next cycle, counters back to 01.
